regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 29 ++
 rtl/wb_fifo.sv | 87 ++++++++
 rtl/regfile_write_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and constants for the register-file write path.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_PC_ALIAS = 5'd31;
    localparam int WB_DATA_W = 64;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_sel_t;

    // r31 reads back as PC+16, so writes to it are architecturally void
    function automatic logic is_pc_alias(input logic [REG_ADDR_W-1:0] addr);
        return addr == REG_PC_ALIAS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Write-back FIFO holding (addr, data) pairs for the register
//               file. With RF_PENDING_QUERY_EN it exposes per-entry addr/valid.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [REG_ADDR_W-1:0]       push_addr,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
`ifdef RF_PENDING_QUERY_EN
    output logic [DEPTH-1:0]            ent_valid,
    output logic [DEPTH*REG_ADDR_W-1:0] ent_addr,
`endif
    output logic [REG_ADDR_W-1:0]       head_addr,
    output logic [WIDTH-1:0]            head_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH_CNT = (c_PTR_W+1)'(DEPTH);

    logic [REG_ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [WIDTH-1:0]      r_data_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;

    // Storage carries no reset; occupancy masks stale contents
    always_ff @(posedge clk) begin
        if (push) begin
            r_addr_mem[r_wr_ptr] <= push_addr;
            r_data_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count     = r_count;
    assign full      = (r_count == c_DEPTH_CNT);
    assign empty     = (r_count == '0);
    assign head_addr = empty ? '0 : r_addr_mem[r_rd_ptr];
    assign head_data = empty ? '0 : r_data_mem[r_rd_ptr];

`ifdef RF_PENDING_QUERY_EN
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_ent
            logic [c_PTR_W-1:0] w_off;
            // Slot i is occupied when its distance from the head is below count
            assign w_off        = c_PTR_W'(i) - r_rd_ptr;
            assign ent_valid[i] = ({1'b0, w_off} < r_count);
            assign ent_addr[i*REG_ADDR_W +: REG_ADDR_W] = r_addr_mem[i];
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin arbiter of ALU/load writes into a FIFO that drains
//               onto the register-file write port; drops r31 writes.
//               Optional pending-write query: RF_PENDING_QUERY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [REG_ADDR_W-1:0]  a_addr,
    input  logic [WIDTH-1:0]       a_data,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [REG_ADDR_W-1:0]  b_addr,
    input  logic [WIDTH-1:0]       b_data,
`ifdef RF_PENDING_QUERY_EN
    input  logic [REG_ADDR_W-1:0]  q_addr,
    output logic                   q_hit,
`endif
    input  logic                   wr_hold,
    output logic                   we3,
    output logic [REG_ADDR_W-1:0]  wa3,
    output logic [WIDTH-1:0]       wd3,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    rr_sel_t               r_rr_sel;
    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_push;
    logic                  w_pop;
    logic [REG_ADDR_W-1:0] w_push_addr;
    logic [WIDTH-1:0]      w_push_data;

    assign w_grant_a = a_valid && !full && (!b_valid || (r_rr_sel == RR_A));
    assign w_grant_b = b_valid && !full && (!a_valid || (r_rr_sel == RR_B));
    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;

    // r31 writes complete the handshake but never reach the FIFO
    assign w_push      = (w_grant_a && !is_pc_alias(a_addr)) ||
                         (w_grant_b && !is_pc_alias(b_addr));
    assign w_push_addr = w_grant_b ? b_addr : a_addr;
    assign w_push_data = w_grant_b ? b_data : a_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_sel <= RR_A;
        end else if (w_grant_a) begin
            r_rr_sel <= RR_B;
        end else if (w_grant_b) begin
            r_rr_sel <= RR_A;
        end
    end

    assign we3   = !empty && !wr_hold;
    assign w_pop = we3;

`ifdef RF_PENDING_QUERY_EN
    logic [DEPTH-1:0]            w_ent_valid;
    logic [DEPTH*REG_ADDR_W-1:0] w_ent_addr;
    logic                        w_hit;

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i] && (w_ent_addr[i*REG_ADDR_W +: REG_ADDR_W] == q_addr)) begin
                w_hit = 1'b1;
            end
        end
        q_hit = w_hit && !is_pc_alias(q_addr);
    end
`endif

    wb_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_addr (w_push_addr),
        .push_data (w_push_data),
        .pop       (w_pop),
`ifdef RF_PENDING_QUERY_EN
        .ent_valid (w_ent_valid),
        .ent_addr  (w_ent_addr),
`endif
        .head_addr (wa3),
        .head_data (wd3),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed self-checking bench for regfile_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, wa3;
    logic [63:0] a_data, b_data, wd3;
    logic        wr_hold, we3, full, empty;
    logic [2:0]  count;
`ifdef RF_PENDING_QUERY_EN
    logic [4:0]  q_addr;
    logic        q_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.WIDTH(64), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
`ifdef RF_PENDING_QUERY_EN
        .q_addr  (q_addr),
        .q_hit   (q_hit),
`endif
        .wr_hold (wr_hold),
        .we3     (we3),
        .wa3     (wa3),
        .wd3     (wd3),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Inputs change 1ns after the rising edge; checks follow 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0;
        a_data = 0; b_data = 0; wr_hold = 0;
`ifdef RF_PENDING_QUERY_EN
        q_addr = 0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full); end
        n_checks++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3: got %0b expected 0", we3); end
        n_checks++; if (wa3 !== 5'd0 || wd3 !== 64'd0) begin n_fail++; $display("FAIL reset_wa3_wd3: got %0d/%0h expected 0/0", wa3, wd3); end
    endtask

    task automatic test_single_write();
        do_reset();
        a_valid = 1; a_addr = 5'd3; a_data = 64'hAA;
        #1;
        n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready: got a=%0b b=%0b expected a=1 b=0", a_ready, b_ready); end
        step();
        a_valid = 0;
        #1;
        n_checks++; if (we3 !== 1'b1 || wa3 !== 5'd3 || wd3 !== 64'hAA) begin n_fail++; $display("FAIL single_write: got we3=%0b wa3=%0d wd3=%0h expected 1/3/aa", we3, wa3, wd3); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
        step();
        #1;
        n_checks++; if (empty !== 1'b1 || we3 !== 1'b0) begin n_fail++; $display("FAIL single_drained: got empty=%0b we3=%0b expected 1/0", empty, we3); end
    endtask

    task automatic test_b_only();
        do_reset();
        b_valid = 1; b_addr = 5'd12; b_data = 64'h1234;
        #1;
        n_checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_fail++; $display("FAIL b_only_ready: got a=%0b b=%0b expected a=0 b=1", a_ready, b_ready); end
        step();
        b_valid = 0;
        #1;
        n_checks++; if (we3 !== 1'b1 || wa3 !== 5'd12 || wd3 !== 64'h1234) begin n_fail++; $display("FAIL b_only_write: got we3=%0b wa3=%0d wd3=%0h expected 1/12/1234", we3, wa3, wd3); end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_wa [4];
        int ai, bi;
        exp_wa[0] = 5'd1; exp_wa[1] = 5'd5; exp_wa[2] = 5'd2; exp_wa[3] = 5'd6;
        ai = 0; bi = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            a_valid = 1; b_valid = 1;
            a_addr = 5'(1 + ai); a_data = 64'(16'h100 + ai);
            b_addr = 5'(5 + bi); b_data = 64'(16'h200 + bi);
            #1;
            n_checks++; if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin n_fail++; $display("FAIL rr_grant[%0d]: got a=%0b b=%0b expected a=%0b b=%0b", k, a_ready, b_ready, (k % 2 == 0), (k % 2 == 1)); end
            if (k > 0) begin
                n_checks++; if (we3 !== 1'b1 || wa3 !== exp_wa[k-1]) begin n_fail++; $display("FAIL rr_order[%0d]: got we3=%0b wa3=%0d expected 1/%0d", k-1, we3, wa3, exp_wa[k-1]); end
            end
            step();
            if (k % 2 == 0) ai++; else bi++;
        end
        a_valid = 0; b_valid = 0;
        #1;
        n_checks++; if (we3 !== 1'b1 || wa3 !== exp_wa[3]) begin n_fail++; $display("FAIL rr_order[3]: got we3=%0b wa3=%0d expected 1/%0d", we3, wa3, exp_wa[3]); end
    endtask

    task automatic test_full_stall();
        do_reset();
        wr_hold = 1;
        for (int i = 0; i < 5; i++) begin
            a_valid = 1; a_addr = 5'(10 + i); a_data = 64'(i);
            #1;
            if (i < 4) begin
                n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %0b expected 1", i, a_ready); end
                step();
            end
        end
        n_checks++; if (a_ready !== 1'b0 || full !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL full_state: got ready=%0b full=%0b count=%0d expected 0/1/4", a_ready, full, count); end
        n_checks++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL hold_we3: got %0b expected 0", we3); end
        wr_hold = 0;
        for (int j = 0; j < 5; j++) begin
            #1;
            n_checks++; if (we3 !== 1'b1 || wa3 !== 5'(10 + j) || wd3 !== 64'(j)) begin n_fail++; $display("FAIL drain[%0d]: got we3=%0b wa3=%0d wd3=%0h expected 1/%0d/%0h", j, we3, wa3, wd3, 10 + j, j); end
            if (j == 0) begin
                n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got %0b expected 0", a_ready); end
            end
            if (j == 1) begin
                n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL fifth_accept: got %0b expected 1", a_ready); end
            end
            step();
            if (j == 1) a_valid = 0;
        end
        #1;
        n_checks++; if (empty !== 1'b1 || we3 !== 1'b0) begin n_fail++; $display("FAIL full_drained: got empty=%0b we3=%0b expected 1/0", empty, we3); end
    endtask

    task automatic test_r31_discard();
        do_reset();
        b_valid = 1; b_addr = 5'd31; b_data = 64'hDEAD;
        #1;
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL r31_ready: got %0b expected 1", b_ready); end
        step();
        b_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (count !== 3'd0 || we3 !== 1'b0) begin n_fail++; $display("FAIL r31_dropped[%0d]: got count=%0d we3=%0b expected 0/0", i, count, we3); end
            step();
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        wr_hold = 1;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; a_addr = 5'(20 + i); a_data = 64'(i);
            step();
        end
        #1;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_prefill: got %0d expected 3", count); end
        // request held across the reset edge must not be accepted
        a_addr = 5'd7; rst_n = 0;
        step();
        rst_n = 1; a_valid = 0; wr_hold = 0;
        #1;
        n_checks++; if (count !== 3'd0 || we3 !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_state: got count=%0d we3=%0b empty=%0b expected 0/0/1", count, we3, empty); end
        a_valid = 1; b_valid = 1;
        #1;
        n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL flush_rr_sel: got a=%0b b=%0b expected a=1 b=0", a_ready, b_ready); end
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            n_checks++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL flush_stale[%0d]: got we3=%0b expected 0", i, we3); end
        end
    endtask

`ifdef RF_PENDING_QUERY_EN
    task automatic test_pending_query();
        do_reset();
        wr_hold = 1;
        a_valid = 1; a_addr = 5'd9; a_data = 64'h99;
        step();
        a_valid = 0; q_addr = 5'd9;
        #1;
        n_checks++; if (q_hit !== 1'b1) begin n_fail++; $display("FAIL query_hit: got %0b expected 1", q_hit); end
        q_addr = 5'd10;
        #1;
        n_checks++; if (q_hit !== 1'b0) begin n_fail++; $display("FAIL query_miss: got %0b expected 0", q_hit); end
        q_addr = 5'd31;
        #1;
        n_checks++; if (q_hit !== 1'b0) begin n_fail++; $display("FAIL query_r31: got %0b expected 0", q_hit); end
        q_addr = 5'd9; wr_hold = 0;
        #1;
        n_checks++; if (q_hit !== 1'b1 || we3 !== 1'b1) begin n_fail++; $display("FAIL query_head_write: got hit=%0b we3=%0b expected 1/1", q_hit, we3); end
        step();
        #1;
        n_checks++; if (q_hit !== 1'b0) begin n_fail++; $display("FAIL query_drained: got %0b expected 0", q_hit); end
    endtask
`endif

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single_write();
        test_b_only();
        test_round_robin();
        test_full_stall();
        test_r31_discard();
        test_reset_flush();
`ifdef RF_PENDING_QUERY_EN
        test_pending_query();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
